seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Sequential shift-and-add multiplier for the P01 datapath. It accepts two DW-bit two's-complement operands and converts each to its magnitude. It then produces the unsigned DW_2-bit magnitude product over DW iterations. The product and both operand MSBs go to the downstream a2 sign stage, which re-applies the sign.

Parameters:
DW, 8, operand width in bits (two's complement)
DW_2, 2*DW, product width in bits; derived, never overridden independently

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to begin a multiplication; sampled only while ready=1
multiplicand  input  DW  two's-complement operand A; sampled on the accepted start cycle
multiplier  input  DW  two's-complement operand B; sampled on the accepted start cycle
ready  output  1  high in IDLE and DONE; block can accept start
done  output  1  single-cycle pulse when product becomes valid
product  output  DW_2  unsigned magnitude product, held until the next accepted start
multiplicand_msb  output  1  registered sign bit of the captured multiplicand
multiplier_msb  output  1  registered sign bit of the captured multiplier

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-CALC):
  - state=IDLE, ready=1, done=0, product=0, both msb outputs=0.
  - Internal accumulator, shift registers and counter are cleared.
  - An operation in flight is abandoned with no done pulse.
- States: IDLE, LOAD, CALC, DONE.
- IDLE:
  - ready=1.
  - start=1 captures the operands and their MSBs, then goes to LOAD.
  - start=0 stays in IDLE.
- LOAD (1 cycle):
  - ready=0.
  - Each operand becomes its magnitude: if MSB=1, magnitude = ~x + 1, kept DW bits wide and treated as unsigned. -2^(DW-1) therefore maps to 2^(DW-1).
  - Accumulator cleared; iteration counter loaded with DW.
  - Next state is CALC.
- CALC (exactly DW cycles):
  - Each cycle, if multiplier-magnitude LSB=1, the zero-extended DW_2-bit multiplicand-magnitude register is added to the accumulator.
  - The multiplicand register then shifts left by 1, the multiplier register shifts right by 1, and the counter decrements.
  - When the counter reaches 1, the state goes to DONE.
- DONE:
  - product <= accumulator.
  - done=1 for exactly this one cycle; ready=1.
  - Then the state goes to IDLE. A start asserted in DONE is accepted exactly as in IDLE and goes straight to LOAD.
- Latency: from the accepted start edge to done high is DW+2 cycles (10 for DW=8). Throughput is one result per DW+2 cycles.
- start while ready=0 is ignored. It is neither queued nor allowed to corrupt operands.
- product, multiplicand_msb and multiplier_msb:
  - The msb outputs update on the accepted start edge.
  - product updates only in DONE.
  - All three hold their values in IDLE.
- Width rule:
  - Maximum magnitude product is 2^(2DW-2), so product[DW_2-1] is always 0.
  - The result always fits product[DW_2-2:0], which is the field the downstream stage consumes.
- Adder is DW_2 bits wide with no carry-out; overflow is impossible by construction.

Optional Feature:
Macro MULT_ZERO_BYPASS_EN.
- Defined: in LOAD, if either magnitude is 0, the block skips CALC and goes straight to DONE with an accumulator of 0. Latency becomes 2 cycles for zero operands; nonzero operands keep DW+2.
- Undefined: every operation takes DW+2 cycles regardless of operand values. No zero-detect logic is present.

Test Plan:
1. Reset, then start with multiplicand=8'd5, multiplier=8'd3 -> done 10 cycles later; product=16'd15; multiplicand_msb=0, multiplier_msb=0.
2. multiplicand=8'hFB (-5), multiplier=8'd3 -> product=16'd15, multiplicand_msb=1, multiplier_msb=0. Feeding these into a2 yields the -15 encoding.
3. multiplicand=8'h80, multiplier=8'h80 -> product=16'h4000, both msbs=1, product[15]=0.
4. Start 5x3, pulse start with 7x7 during CALC, then start 7x7 in the DONE cycle:
   - First result is 15, unaffected by the ignored start.
   - The second request is accepted in DONE and yields 49 ten cycles later.
5. Start 100x100, assert rst in the 4th CALC cycle:
   - No done pulse occurs; outputs go to 0 and ready=1 the next cycle.
   - A following 2x2 then yields 4.
6. multiplicand=0, multiplier=8'd9 -> product=0. done arrives after 2 cycles with MULT_ZERO_BYPASS_EN defined, after 10 cycles without it.

Source files
------------

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-and-add magnitude multiplier (MULT_ZERO_BYPASS_EN: skip CALC on zero operand)
// Sign bits are only captured; the downstream sign stage re-applies them to the magnitude product.
module seq_multiplier #(
    parameter int DW   = 8,
    parameter int DW_2 = 2 * DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            ready,
    output logic            done,
    output logic [DW_2-1:0] product,
    output logic            multiplicand_msb,
    output logic            multiplier_msb
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW_2-1:0] mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [DW_2-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [DW_2-1:0] product_q, product_d;
    logic            mcand_msb_q, mcand_msb_d;
    logic            mplier_msb_q, mplier_msb_d;

    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic [DW_2-1:0] sum;

    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        product_d    = product_q;
        mcand_msb_d  = mcand_msb_q;
        mplier_msb_d = mplier_msb_q;

        // Magnitudes stay DW bits wide, so the most negative value maps to 2^(DW-1).
        mag_a = mcand_msb_q ? (~mcand_q[DW-1:0] + DW'(1)) : mcand_q[DW-1:0];
        mag_b = mplier_msb_q ? (~mplier_q + DW'(1)) : mplier_q;
        sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d      = DW_2'(multiplicand);
                    mplier_d     = multiplier;
                    mcand_msb_d  = multiplicand[DW-1];
                    mplier_msb_d = multiplier[DW-1];
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                mcand_d = DW_2'(mag_a);
                mplier_d = mag_b;
                acc_d   = '0;
                cnt_d   = CNT_INIT;
                state_d = S_CALC;
`ifdef MULT_ZERO_BYPASS_EN
                if ((mag_a == '0) || (mag_b == '0)) begin
                    state_d   = S_DONE;
                    product_d = '0;
                    done_d    = 1'b1;
                end
`endif
            end
            S_CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Product is registered on entry to DONE so it is valid while done is high.
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    product_d = sum;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            product_q    <= '0;
            mcand_msb_q  <= 1'b0;
            mplier_msb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            product_q    <= product_d;
            mcand_msb_q  <= mcand_msb_d;
            mplier_msb_q <= mplier_msb_d;
        end
    end

    assign ready            = ready_q;
    assign done             = done_q;
    assign product          = product_q;
    assign multiplicand_msb = mcand_msb_q;
    assign multiplier_msb   = mplier_msb_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        done;
    logic [15:0] product;
    logic        multiplicand_msb;
    logic        multiplier_msb;

    int n_checks;
    int n_fail;
    int lat;
    int done_seen;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 10;
`endif

    seq_multiplier dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .multiplicand     (multiplicand),
        .multiplier       (multiplier),
        .ready            (ready),
        .done             (done),
        .product          (product),
        .multiplicand_msb (multiplicand_msb),
        .multiplier_msb   (multiplier_msb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        lat          = 0;
        step();
        start        = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && lat < 40) step();
    endtask

    task automatic check_result(input string tag, input int exp_lat, input logic [15:0] exp_p,
                                input logic exp_ma, input logic exp_mb);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_product"}, 32'(product), 32'(exp_p));
        chk({tag, "_mcand_msb"}, 32'(multiplicand_msb), 32'(exp_ma));
        chk({tag, "_mplier_msb"}, 32'(multiplier_msb), 32'(exp_mb));
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    task automatic check_idle_after(input string tag, input logic [15:0] exp_p);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_msbs", 32'({multiplicand_msb, multiplier_msb}), 32'd0);

        launch(8'd5, 8'd3);
        chk("busy_ready", 32'(ready), 32'd0);
        wait_done();
        check_result("5x3", 10, 16'd15, 1'b0, 1'b0);
        check_idle_after("5x3", 16'd15);

        launch(8'hFB, 8'd3);
        wait_done();
        check_result("m5x3", 10, 16'd15, 1'b1, 1'b0);
        check_idle_after("m5x3", 16'd15);

        launch(8'h80, 8'h80);
        wait_done();
        check_result("m128sq", 10, 16'h4000, 1'b1, 1'b1);
        chk("m128sq_top_bit", 32'(product[15]), 32'd0);
        check_idle_after("m128sq", 16'h4000);

        launch(8'hFD, 8'hF9);
        wait_done();
        check_result("m3xm7", 10, 16'd21, 1'b1, 1'b1);
        check_idle_after("m3xm7", 16'd21);

        launch(8'd127, 8'h80);
        wait_done();
        check_result("127xm128", 10, 16'h3F80, 1'b0, 1'b1);
        check_idle_after("127xm128", 16'h3F80);

        launch(8'hFF, 8'hFF);
        wait_done();
        check_result("m1xm1", 10, 16'd1, 1'b1, 1'b1);
        check_idle_after("m1xm1", 16'd1);

        // Start pulsed mid-CALC must be ignored; start in DONE must be accepted.
        launch(8'd5, 8'd3);
        repeat (3) step();
        chk("ign_ready", 32'(ready), 32'd0);
        multiplicand = 8'd7;
        multiplier   = 8'd7;
        start        = 1'b1;
        step();
        start        = 1'b0;
        wait_done();
        check_result("ign_first", 10, 16'd15, 1'b0, 1'b0);
        launch(8'd7, 8'd7);
        chk("b2b_accept_ready", 32'(ready), 32'd0);
        wait_done();
        check_result("b2b_second", 10, 16'd49, 1'b0, 1'b0);
        check_idle_after("b2b_second", 16'd49);

        // Reset in the 4th CALC cycle abandons the operation.
        launch(8'd100, 8'd100);
        repeat (4) step();
        chk("abort_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_msbs", 32'({multiplicand_msb, multiplier_msb}), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        launch(8'd2, 8'd2);
        wait_done();
        check_result("2x2", 10, 16'd4, 1'b0, 1'b0);
        check_idle_after("2x2", 16'd4);

        launch(8'd0, 8'd9);
        wait_done();
        check_result("0x9", ZERO_LAT, 16'd0, 1'b0, 1'b0);
        check_idle_after("0x9", 16'd0);

        launch(8'd6, 8'd0);
        wait_done();
        check_result("6x0", ZERO_LAT, 16'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
